// File: rtl/regression_scheduler_pkg.sv
// Shared types and constants for the regression batch scheduler.
// Holds FSM encoding, channel ID type and default batch/timeout sizes.
package regression_scheduler_pkg;

  localparam int unsigned N_SAMPLES_DEF = 8;
  localparam int unsigned TIMEOUT_DEF   = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  typedef logic ch_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// The pointer remembers the last served channel; the other one wins a tie.
module rr_arbiter2
  import regression_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  ch_t  upd_ch_i,
  output logic gnt_o,
  output ch_t  ch_o
);

  ch_t last_q;

  // Reset to 1 so channel 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_ch_i;
    end
  end

  always_comb begin
    gnt_o = req0_i | req1_i;
    ch_o  = 1'b0;
    unique case (1'b1)
      (req0_i && req1_i):  ch_o = ~last_q;
      (req1_i && !req0_i): ch_o = 1'b1;
      default:             ch_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/regression_scheduler.sv
// Batches samples from two requesters into a regression engine,
// then holds the engine result (or a timeout error) for a consumer.
module regression_scheduler
  import regression_scheduler_pkg::*;
#(
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  output logic        req1_ready,
  output logic        eng_start,
  output logic        eng_valid,
  output logic [15:0] eng_x,
  output logic [15:0] eng_y,
  input  logic        eng_done,
  input  logic [31:0] eng_b1,
  input  logic [31:0] eng_b0,
  input  logic [31:0] eng_mse,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_ch,
  output logic        res_err,
  output logic [31:0] res_b1,
  output logic [31:0] res_b0,
  output logic [31:0] res_mse,
  output logic        busy
);

  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  ch_t           grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          start_q, start_d;
  logic          evld_q, evld_d;
  logic [15:0]   ex_q, ex_d;
  logic [15:0]   ey_q, ey_d;
  logic          rvld_q, rvld_d;
  ch_t           rch_q, rch_d;
  logic          rerr_q, rerr_d;
  logic [31:0]   rb1_q, rb1_d;
  logic [31:0]   rb0_q, rb0_d;
  logic [31:0]   rmse_q, rmse_d;

  logic        arb_gnt;
  ch_t         arb_ch;
  logic        in_stream;
  logic        sel_valid;
  logic [15:0] sel_x;
  logic [15:0] sel_y;
  logic        hs;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .upd_i    (rvld_q & res_ready),
    .upd_ch_i (rch_q),
    .gnt_o    (arb_gnt),
    .ch_o     (arb_ch)
  );

  assign in_stream  = (state_q == ST_STREAM);
  assign req0_ready = in_stream & ~grant_q;
  assign req1_ready = in_stream & grant_q;
  assign sel_valid  = grant_q ? req1_valid : req0_valid;
  assign sel_x      = grant_q ? req1_x : req0_x;
  assign sel_y      = grant_q ? req1_y : req0_y;
  assign hs         = in_stream & sel_valid;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    evld_d  = hs;
    ex_d    = hs ? sel_x : ex_q;
    ey_d    = hs ? sel_y : ey_q;
    rvld_d  = rvld_q;
    rch_d   = rch_q;
    rerr_d  = rerr_q;
    rb1_d   = rb1_q;
    rb0_d   = rb0_q;
    rmse_d  = rmse_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt) begin
          state_d = ST_STREAM;
          grant_d = arb_ch;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        if (hs) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_SAMPLES - 1)) begin
            state_d = ST_WAIT;
            tmo_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        // A done pulse on the expiry cycle still delivers real results.
        if (eng_done) begin
          state_d = ST_RESULT;
          rvld_d  = 1'b1;
          rch_d   = grant_q;
          rerr_d  = 1'b0;
          rb1_d   = eng_b1;
          rb0_d   = eng_b0;
          rmse_d  = eng_mse;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_RESULT;
          rvld_d  = 1'b1;
          rch_d   = grant_q;
          rerr_d  = 1'b1;
          rb1_d   = '0;
          rb0_d   = '0;
          rmse_d  = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          rvld_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      evld_q  <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      rvld_q  <= 1'b0;
      rch_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rb1_q   <= '0;
      rb0_q   <= '0;
      rmse_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      evld_q  <= evld_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      rvld_q  <= rvld_d;
      rch_q   <= rch_d;
      rerr_q  <= rerr_d;
      rb1_q   <= rb1_d;
      rb0_q   <= rb0_d;
      rmse_q  <= rmse_d;
    end
  end

  assign eng_start = start_q;
  assign eng_valid = evld_q;
  assign eng_x     = ex_q;
  assign eng_y     = ey_q;
  assign res_valid = rvld_q;
  assign res_ch    = rch_q;
  assign res_err   = rerr_q;
  assign res_b1    = rb1_q;
  assign res_b0    = rb0_q;
  assign res_mse   = rmse_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regression_scheduler.sv
// Directed bench for regression_scheduler: single batch, contention,
// stall, timeout, done-at-expiry, result backpressure and mid-batch reset.
module tb_regression_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic        req0_ready, req1_ready;
  logic        eng_start, eng_valid;
  logic [15:0] eng_x, eng_y;
  logic        eng_done;
  logic [31:0] eng_b1, eng_b0, eng_mse;
  logic        res_valid, res_ready, res_ch, res_err;
  logic [31:0] res_b1, res_b0, res_mse;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int es_cnt = 0;
  int ev_cnt = 0;
  int rv_cnt = 0;
  int es0, ev0, rv0, n;

  always #5 clk = ~clk;

  regression_scheduler #(.N_SAMPLES(8), .TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ready (req1_ready),
    .eng_start  (eng_start),
    .eng_valid  (eng_valid),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_done   (eng_done),
    .eng_b1     (eng_b1),
    .eng_b0     (eng_b0),
    .eng_mse    (eng_mse),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ch     (res_ch),
    .res_err    (res_err),
    .res_b1     (res_b1),
    .res_b0     (res_b0),
    .res_mse    (res_mse),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (eng_start) es_cnt++;
    if (eng_valid) ev_cnt++;
    if (res_valid) rv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one sample on ch and confirm it reaches the engine one cycle later.
  task automatic xfer(input bit ch, input logic [15:0] x,
                      input logic [15:0] y);
    int g;
    g = 0;
    if (ch) begin
      req1_valid = 1'b1; req1_x = x; req1_y = y;
    end else begin
      req0_valid = 1'b1; req0_x = x; req0_y = y;
    end
    while (!(ch ? req1_ready : req0_ready) && g < 300) begin
      tick();
      g++;
    end
    check("xfer_ready", ch ? req1_ready : req0_ready, 1);
    check("xfer_other_ready", ch ? req0_ready : req1_ready, 0);
    tick();
    check("eng_valid", eng_valid, 1);
    check("eng_xy", {eng_x, eng_y}, {x, y});
  endtask

  task automatic finish_batch(input bit ch, input logic [31:0] b1,
                              input logic [31:0] b0, input logic [31:0] mse);
    tick();
    tick();
    eng_b1 = b1; eng_b0 = b0; eng_mse = mse;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("res_valid", res_valid, 1);
    check("res_ch", res_ch, ch);
    check("res_err", res_err, 0);
    check("res_b1", res_b1, b1);
    check("res_b0", res_b0, b0);
    check("res_mse", res_mse, mse);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_drop", {res_valid, busy}, 0);
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0;
    eng_done = 0; eng_b1 = 0; eng_b0 = 0; eng_mse = 0;
    res_ready = 0;
    repeat (3) tick();
    check("rst_ctrl", {req0_ready, req1_ready, eng_start, eng_valid,
                       res_valid, res_ch, res_err, busy}, 0);
    check("rst_data", {eng_x, eng_y, res_b1}, 0);
    check("rst_data2", {res_b0, res_mse}, 0);
    rst = 1'b1;

    // Engine done while idle must be ignored
    eng_b1 = 32'h55; eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("idle_done_ignored", {res_valid, busy}, 0);

    // Single channel batch
    es0 = es_cnt; ev0 = ev_cnt;
    for (int i = 1; i <= 8; i++) xfer(0, 16'(i), 16'(2 * i + 1));
    req0_valid = 1'b0;
    check("single_wait", {req0_ready, busy}, 2'b01);
    finish_batch(0, 32'd2, 32'd1, 32'd0);
    check("single_starts", es_cnt - es0, 1);
    check("single_valids", ev_cnt - ev0, 8);

    // Contention from reset: ch0, ch1, ch0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_x = 16'h0100; req1_y = 16'h0200;
    tick();
    check("cont0_grant", {req1_ready, req0_ready}, 2'b01);
    check("cont0_start", eng_start, 1);
    for (int i = 0; i < 8; i++) xfer(0, 16'h10 + 16'(i), 16'h20 + 16'(i));
    finish_batch(0, 32'hA, 32'hB, 32'hC);
    tick();
    check("cont1_grant", {req1_ready, req0_ready}, 2'b10);
    for (int i = 0; i < 8; i++) xfer(1, 16'h40 + 16'(i), 16'hFFF0 - 16'(i));
    finish_batch(1, 32'hD, 32'hE, 32'hF);
    tick();
    check("cont2_grant", {req1_ready, req0_ready}, 2'b01);
    for (int i = 0; i < 8; i++) xfer(0, 16'h70 + 16'(i), 16'h80);
    req0_valid = 1'b0; req1_valid = 1'b0;
    finish_batch(0, 32'h1, 32'h2, 32'h3);

    // Stall after sample 3 for 5 cycles, stray done during stream
    es0 = es_cnt; ev0 = ev_cnt;
    for (int i = 1; i <= 3; i++) xfer(0, 16'h30 + 16'(i), 16'(i));
    req0_valid = 1'b0;
    tick();
    check("stall_no_valid", eng_valid, 0);
    check("stall_hold_x", eng_x, 16'h33);
    eng_b1 = 32'hBAD; eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    repeat (3) tick();
    check("stall_ready", {req0_ready, res_valid}, 2'b10);
    for (int i = 4; i <= 8; i++) xfer(0, 16'h30 + 16'(i), 16'(i));
    req0_valid = 1'b0;
    finish_batch(0, 32'h44, 32'h55, 32'h66);
    check("stall_valids", ev_cnt - ev0, 8);
    check("stall_starts", es_cnt - es0, 1);

    // Timeout with no engine response
    for (int i = 0; i < 8; i++) xfer(1, 16'h90 + 16'(i), 16'h9);
    req1_valid = 1'b0;
    eng_b1 = 32'hDEAD0001; eng_b0 = 32'hDEAD0002; eng_mse = 32'hDEAD0003;
    n = 0;
    while (!res_valid && n < 400) begin
      tick();
      n++;
    end
    check("to_cycles", n, 255);
    check("to_err_ch", {res_err, res_ch}, 2'b11);
    check("to_b1_b0", {res_b1, res_b0}, 0);
    check("to_mse", res_mse, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Done on the expiry cycle wins
    for (int i = 0; i < 8; i++) xfer(0, 16'hA0 + 16'(i), 16'hA);
    req0_valid = 1'b0;
    repeat (254) tick();
    check("d255_pre", res_valid, 0);
    eng_b1 = 32'h11111111; eng_b0 = 32'h22222222; eng_mse = 32'h33;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("d255_valid", {res_valid, res_err, res_ch}, 3'b100);
    check("d255_b1", res_b1, 32'h11111111);

    // Result backpressure with ch1 waiting
    req1_valid = 1'b1; req1_x = 16'h5; req1_y = 16'h6;
    eng_b1 = 32'hFFFF0000; eng_b0 = 32'hFFFF0001;
    for (int k = 0; k < 10; k++) begin
      eng_done = (k == 4);
      tick();
      check("bp_hold", {res_valid, res_err, res_ch, req1_ready,
                        eng_start, res_b1},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111});
    end
    eng_done = 1'b0;
    check("bp_hold_b0", {res_b0, res_mse}, {32'h22222222, 32'h33});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_release", res_valid, 0);
    tick();
    check("bp_grant", {req1_ready, eng_start}, 2'b11);

    // Reset at sample 5 of a ch1 batch
    for (int i = 1; i <= 4; i++) xfer(1, 16'hC0 + 16'(i), 16'hC);
    rv0 = rv_cnt;
    req1_x = 16'hC5;
    rst = 1'b0;
    tick();
    check("rstmid_ctrl", {req0_ready, req1_ready, eng_start, eng_valid,
                          res_valid, res_ch, res_err, busy}, 0);
    check("rstmid_data", {eng_x, eng_y, res_b1}, 0);
    check("rstmid_data2", {res_b0, res_mse}, 0);
    rst = 1'b1;
    req1_valid = 1'b0;
    repeat (20) tick();
    check("rstmid_no_res", rv_cnt - rv0, 0);
    check("rstmid_idle", busy, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    check("rstmid_tie", {req1_ready, req0_ready}, 2'b01);
    for (int i = 0; i < 8; i++) xfer(0, 16'hE0 + 16'(i), 16'hE);
    req0_valid = 1'b0; req1_valid = 1'b0;
    finish_batch(0, 32'h7, 32'h8, 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
